// File: rtl/gemm_ctrl.sv
// GEMM loop-nest sequencer: walks i/j/k, issues A/B reads, MAC strobes and C writes.
// Optional perf counters (perf_cycles, perf_stalls) under `GEMM_CTRL_PERF_CNT_EN.
module gemm_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BASE_A     = 0,
    parameter int unsigned BASE_B     = 0,
    parameter int unsigned BASE_C     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            M_dimmension,
    input  logic [7:0]            K_dimmension,
    input  logic [7:0]            N_dimmension,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  dim_err,
    output logic                  read_enable_A,
    output logic [ADDR_WIDTH-1:0] address_A,
    output logic                  read_enable_B,
    output logic [ADDR_WIDTH-1:0] address_B,
    output logic                  mac_valid,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic                  write_enable_C,
    output logic [ADDR_WIDTH-1:0] address_C
`ifdef GEMM_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t state, state_next;

    logic [7:0] m_dim, k_dim, n_dim;
    logic [7:0] i_cnt, j_cnt, k_cnt;
    logic       k_end, j_end, i_end;
    logic       dims_ok, accept, reject, issue;

    logic [15:0]           prod_a, prod_b, prod_c;
    logic [ADDR_WIDTH-1:0] addr_a_raw, addr_b_raw, addr_c_issue;

    logic                  s2_valid, s2_first, s2_last;
    logic [ADDR_WIDTH-1:0] s2_addr_c;
    logic                  s3_valid;
    logic [ADDR_WIDTH-1:0] s3_addr_c;

    assign dims_ok = (M_dimmension != 8'd0) && (K_dimmension != 8'd0) && (N_dimmension != 8'd0);
    assign k_end   = (k_cnt == 8'(k_dim - 8'd1));
    assign j_end   = (j_cnt == 8'(n_dim - 8'd1));
    assign i_end   = (i_cnt == 8'(m_dim - 8'd1));
    assign issue   = (state == RUN) && !stall;

    // 8x8 products, then address sums wrap modulo 2^ADDR_WIDTH
    assign prod_a       = 16'(i_cnt) * 16'(k_dim);
    assign prod_b       = 16'(k_cnt) * 16'(n_dim);
    assign prod_c       = 16'(i_cnt) * 16'(n_dim);
    assign addr_a_raw   = ADDR_WIDTH'(BASE_A + 32'(prod_a) + 32'(k_cnt));
    assign addr_b_raw   = ADDR_WIDTH'(BASE_B + 32'(prod_b) + 32'(j_cnt));
    assign addr_c_issue = ADDR_WIDTH'(BASE_C + 32'(prod_c) + 32'(j_cnt));

    // Strobes are gated by stall in the same cycle; addresses read 0 when idle
    assign read_enable_A  = issue;
    assign read_enable_B  = issue;
    assign address_A      = issue ? addr_a_raw : '0;
    assign address_B      = issue ? addr_b_raw : '0;
    assign mac_valid      = s2_valid && !stall;
    assign mac_first      = mac_valid && s2_first;
    assign mac_last       = mac_valid && s2_last;
    assign write_enable_C = s3_valid && !stall;
    assign address_C      = write_enable_C ? s3_addr_c : '0;

    // Next-state logic
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (dims_ok) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        reject     = 1'b1;
                    end
                end
            end
            RUN:   if (issue && k_end && j_end && i_end) state_next = DRAIN;
            DRAIN: if (!stall && !s2_valid && !s3_valid) state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dim_err <= 1'b0;
        end else begin
            state   <= state_next;
            busy    <= (state_next == RUN) || (state_next == DRAIN);
            done    <= (state_next == FIN);
            dim_err <= reject;
        end
    end

    // Loop-nest counters; k innermost, i outermost
    always_ff @(posedge clk) begin
        if (reset) begin
            m_dim <= 8'd0;
            k_dim <= 8'd0;
            n_dim <= 8'd0;
            i_cnt <= 8'd0;
            j_cnt <= 8'd0;
            k_cnt <= 8'd0;
        end else if (accept) begin
            m_dim <= M_dimmension;
            k_dim <= K_dimmension;
            n_dim <= N_dimmension;
            i_cnt <= 8'd0;
            j_cnt <= 8'd0;
            k_cnt <= 8'd0;
        end else if (issue) begin
            if (k_end) begin
                k_cnt <= 8'd0;
                if (j_end) begin
                    j_cnt <= 8'd0;
                    i_cnt <= i_end ? 8'd0 : 8'(i_cnt + 8'd1);
                end else begin
                    j_cnt <= 8'(j_cnt + 8'd1);
                end
            end else begin
                k_cnt <= 8'(k_cnt + 8'd1);
            end
        end
    end

    // MAC stage and C-write stage; both freeze under stall
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_addr_c <= '0;
            s3_valid  <= 1'b0;
            s3_addr_c <= '0;
        end else if (!stall) begin
            s2_valid  <= issue;
            s2_first  <= (k_cnt == 8'd0);
            s2_last   <= k_end;
            s2_addr_c <= addr_c_issue;
            s3_valid  <= s2_valid && s2_last;
            s3_addr_c <= s2_addr_c;
        end
    end

`ifdef GEMM_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= 32'd0;
            perf_stalls <= 32'd0;
        end else if (accept) begin
            perf_cycles <= 32'd0;
            perf_stalls <= 32'd0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (stall) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
